// File: rtl/key_debounce_array.sv
// Multi-channel key debouncer: two-flop synchroniser plus one press/hold/release FSM per key,
// with long-press detection and gated auto-repeat. Every output comes straight from a flop.

module key_debounce_chan #(
  parameter int unsigned CW           = 8,
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned LONG_CYC     = 20,
  parameter int unsigned REPEAT_CYC   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pressed_i,
  input  logic repeat_en_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HOLD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } state_e;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] LG_LAST  = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_CYC - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic          long_done_q, long_done_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          repeat_q, repeat_d;

  // State, counters and output pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dcnt_q      <= CNT_ZERO;
      hcnt_q      <= CNT_ZERO;
      rcnt_q      <= CNT_ZERO;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      hcnt_q      <= hcnt_d;
      rcnt_q      <= rcnt_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
    end
  end

  // Next-state, counter and pulse logic
  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    hcnt_d      = hcnt_q;
    rcnt_d      = rcnt_q;
    long_done_d = long_done_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    repeat_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pressed_i) begin
          state_d = ST_PRESS_DB;
          dcnt_d  = CNT_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRESS_DB: begin
        if (!pressed_i) begin
          state_d = ST_IDLE;
          dcnt_d  = CNT_ZERO;
        end else if (dcnt_q == DB_LAST) begin
          state_d = ST_HOLD;
          dcnt_d  = CNT_ZERO;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          dcnt_d = dcnt_q + CNT_ONE;
        end
      end
      ST_HOLD: begin
        // Hold timing runs on every HOLD cycle, including the one that starts a release bounce
        if (!long_done_q) begin
          if (hcnt_q == LG_LAST) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
          end else begin
            hcnt_d = hcnt_q + CNT_ONE;
          end
        end else if (repeat_en_i) begin
          if (rcnt_q == RP_LAST) begin
            rcnt_d   = CNT_ZERO;
            repeat_d = 1'b1;
          end else begin
            rcnt_d = rcnt_q + CNT_ONE;
          end
        end else begin
          rcnt_d = CNT_ZERO;
        end
        if (!pressed_i) begin
          state_d = ST_RELEASE_DB;
          dcnt_d  = CNT_ZERO;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_RELEASE_DB: begin
        if (pressed_i) begin
          state_d = ST_HOLD;
          dcnt_d  = CNT_ZERO;
        end else if (dcnt_q == DB_LAST) begin
          state_d     = ST_IDLE;
          dcnt_d      = CNT_ZERO;
          hcnt_d      = CNT_ZERO;
          rcnt_d      = CNT_ZERO;
          long_done_d = 1'b0;
          level_d     = 1'b0;
          release_d   = 1'b1;
        end else begin
          dcnt_d = dcnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        dcnt_d      = CNT_ZERO;
        hcnt_d      = CNT_ZERO;
        rcnt_d      = CNT_ZERO;
        long_done_d = 1'b0;
        level_d     = 1'b0;
      end
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;

endmodule

module key_debounce_array #(
  parameter int unsigned WIDTH        = 5,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned LONG_CYC     = 50_000_000,
  parameter int unsigned REPEAT_CYC   = 10_000_000,
  parameter int unsigned ACTIVE_LOW   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] key_in,
  input  logic             repeat_en,
  output logic [WIDTH-1:0] key_level,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release,
  output logic [WIDTH-1:0] key_long,
  output logic [WIDTH-1:0] key_repeat
);

  localparam int unsigned MAX_DL  = (DEBOUNCE_CYC > LONG_CYC) ? DEBOUNCE_CYC : LONG_CYC;
  localparam int unsigned MAX_CYC = (MAX_DL > REPEAT_CYC) ? MAX_DL : REPEAT_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC) + 1;
  localparam logic        AL_BIT  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [WIDTH-1:0] RELEASED = {WIDTH{AL_BIT}};

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] pressed_s;

  // Two-flop synchroniser; resets to the released level so reset never fakes a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RELEASED;
      sync2_q <= RELEASED;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  assign pressed_s = sync2_q ^ RELEASED;

  for (genvar g = 0; g < int'(WIDTH); g++) begin : g_chan
    key_debounce_chan #(
      .CW           (CW),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .REPEAT_CYC   (REPEAT_CYC)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .pressed_i   (pressed_s[g]),
      .repeat_en_i (repeat_en),
      .level_o     (key_level[g]),
      .press_o     (key_press[g]),
      .release_o   (key_release[g]),
      .long_o      (key_long[g]),
      .repeat_o    (key_repeat[g])
    );
  end

endmodule

// File: tb/tb_key_debounce_array.sv
// Bench for key_debounce_array: an active-low and an active-high instance see the same keys
// and are compared every cycle against a run-length reference model, plus directed latencies.

module tb_key_debounce_array;

  localparam int W  = 3;
  localparam int DB = 4;
  localparam int LG = 20;
  localparam int RP = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         repeat_en = 1'b0;
  logic [W-1:0] key_in = '1;
  logic [W-1:0] key_in_hi;
  logic [W-1:0] lvl_a, prs_a, rel_a, lng_a, rpt_a;
  logic [W-1:0] lvl_b, prs_b, rel_b, lng_b, rpt_b;

  assign key_in_hi = ~key_in;

  always #5 clk = ~clk;

  key_debounce_array #(.WIDTH(W), .DEBOUNCE_CYC(DB), .LONG_CYC(LG), .REPEAT_CYC(RP), .ACTIVE_LOW(1))
  dut_a (.clk(clk), .rst_n(rst_n), .key_in(key_in), .repeat_en(repeat_en), .key_level(lvl_a),
         .key_press(prs_a), .key_release(rel_a), .key_long(lng_a), .key_repeat(rpt_a));

  key_debounce_array #(.WIDTH(W), .DEBOUNCE_CYC(DB), .LONG_CYC(LG), .REPEAT_CYC(RP), .ACTIVE_LOW(0))
  dut_b (.clk(clk), .rst_n(rst_n), .key_in(key_in_hi), .repeat_en(repeat_en), .key_level(lvl_b),
         .key_press(prs_b), .key_release(rel_b), .key_long(lng_b), .key_repeat(rpt_b));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: raw key history, then per key a run of samples disagreeing with the level
  logic [W-1:0] ms1, ms2;
  logic [W-1:0] e_lvl, e_prs, e_rel, e_lng, e_rpt;
  int           run  [W];
  int           held [W];
  int           rep  [W];
  bit           mdone[W];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    ms1 = '1;
    ms2 = '1;
    e_lvl = '0; e_prs = '0; e_rel = '0; e_lng = '0; e_rpt = '0;
    for (int i = 0; i < W; i++) begin
      run[i] = 0; held[i] = 0; rep[i] = 0; mdone[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [W-1:0] k, input logic ren);
    logic p;
    e_prs = '0; e_rel = '0; e_lng = '0; e_rpt = '0;
    for (int i = 0; i < W; i++) begin
      p = ~ms2[i];
      // Held time only accrues while the key is accepted and no release bounce is pending
      if (e_lvl[i] && run[i] == 0) begin
        if (!mdone[i]) begin
          held[i]++;
          if (held[i] == LG) begin
            e_lng[i] = 1'b1;
            mdone[i] = 1'b1;
          end
        end else if (ren) begin
          rep[i]++;
          if (rep[i] == RP) begin
            e_rpt[i] = 1'b1;
            rep[i] = 0;
          end
        end else begin
          rep[i] = 0;
        end
      end
      if (p != e_lvl[i]) begin
        run[i]++;
        if (run[i] == DB + 1) begin
          run[i] = 0;
          e_lvl[i] = p;
          if (p) begin
            e_prs[i] = 1'b1;
          end else begin
            e_rel[i] = 1'b1;
            held[i] = 0;
            rep[i] = 0;
            mdone[i] = 1'b0;
          end
        end
      end else begin
        run[i] = 0;
      end
    end
    ms2 = ms1;
    ms1 = k;
  endtask

  task automatic compare();
    chk("level_al", 32'(lvl_a), 32'(e_lvl));
    chk("press_al", 32'(prs_a), 32'(e_prs));
    chk("release_al", 32'(rel_a), 32'(e_rel));
    chk("long_al", 32'(lng_a), 32'(e_lng));
    chk("repeat_al", 32'(rpt_a), 32'(e_rpt));
    chk("level_ah", 32'(lvl_b), 32'(e_lvl));
    chk("press_ah", 32'(prs_b), 32'(e_prs));
    chk("release_ah", 32'(rel_b), 32'(e_rel));
    chk("long_ah", 32'(lng_b), 32'(e_lng));
    chk("repeat_ah", 32'(rpt_b), 32'(e_rpt));
  endtask

  task automatic step();
    logic [W-1:0] k;
    logic         r;
    k = key_in;
    r = repeat_en;
    @(posedge clk);
    if (rst_n) model_edge(k, r);
    #1;
    compare();
    cyc++;
  endtask

  function automatic logic [W-1:0] sel(input int kind);
    case (kind)
      0:       return prs_a;
      1:       return lng_a;
      2:       return rpt_a;
      default: return rel_a;
    endcase
  endfunction

  // Count edges until the selected event on bit idx; an expired bound yields n == bound
  task automatic wait_ev(input int kind, input int idx, input int bound, output int n);
    logic [W-1:0] v;
    n = 0;
    do begin
      step();
      n++;
      v = sel(kind);
    end while (!v[idx] && n < bound);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    compare();
    steps(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int dur [W];
    model_reset();
    #2;
    do_reset();
    steps(3);

    // Clean press on key 0 with auto-repeat enabled, held ~60 cycles
    repeat_en = 1'b1;
    key_in[0] = 1'b0;
    wait_ev(0, 0, 30, n); chk("press_latency", 32'(n), 32'd7);
    wait_ev(1, 0, 40, n); chk("long_after_press", 32'(n), 32'd20);
    wait_ev(2, 0, 20, n); chk("repeat1", 32'(n), 32'd8);
    wait_ev(2, 0, 20, n); chk("repeat2", 32'(n), 32'd8);
    wait_ev(2, 0, 20, n); chk("repeat3", 32'(n), 32'd8);
    steps(16);
    key_in[0] = 1'b1;
    wait_ev(3, 0, 30, n); chk("release_latency", 32'(n), 32'd7);
    steps(6);

    // Bounce rejection on key 1
    for (int r = 0; r < 5; r++) begin
      key_in[1] = 1'b0; steps(3);
      key_in[1] = 1'b1; steps(3);
    end
    steps(8);

    // Repeat gating: enable 10 cycles after key_long
    repeat_en = 1'b0;
    key_in[0] = 1'b0;
    wait_ev(0, 0, 30, n); chk("press_latency2", 32'(n), 32'd7);
    wait_ev(1, 0, 40, n); chk("long_gated", 32'(n), 32'd20);
    steps(10);
    repeat_en = 1'b1;
    wait_ev(2, 0, 20, n); chk("repeat_after_enable", 32'(n), 32'd8);
    key_in[0] = 1'b1;
    steps(12);

    // Two-cycle release glitch on held key 2 delays key_long by two cycles
    key_in[2] = 1'b0;
    wait_ev(0, 2, 30, n); chk("press_latency_k2", 32'(n), 32'd7);
    steps(5);
    key_in[2] = 1'b1; steps(2);
    key_in[2] = 1'b0;
    wait_ev(1, 2, 40, n); chk("long_after_glitch", 32'(n), 32'd15);
    key_in[2] = 1'b1;
    steps(12);

    // Reset in the middle of HOLD with the key still down
    key_in[0] = 1'b0;
    wait_ev(0, 0, 30, n); chk("press_before_reset", 32'(n), 32'd7);
    steps(5);
    do_reset();
    wait_ev(0, 0, 30, n); chk("press_after_reset", 32'(n), 32'd7);
    key_in[0] = 1'b1;
    steps(12);

    // Randomised mix of bounces, long holds, repeat gating and rare resets
    for (int i = 0; i < W; i++) dur[i] = $urandom_range(0, 20);
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < W; i++) begin
        if (dur[i] == 0) begin
          key_in[i] = ~key_in[i];
          if ($urandom_range(0, 2) == 0) dur[i] = $urandom_range(1, 5);
          else dur[i] = $urandom_range(6, 70);
        end else begin
          dur[i]--;
        end
      end
      if ($urandom_range(0, 199) == 0) repeat_en = ~repeat_en;
      if ($urandom_range(0, 1499) == 0) do_reset();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
